floo_wormhole_arbiter: RTL and testbench
========================================

// Module: floo_wormhole_arbiter
// PURPOSE
//  Shares one router output port among NumInputs requesting input ports with wormhole semantics.
//  Round-robin arbitration picks a winner per packet. The winner holds the output until the flit
//  carrying hdr.last is transferred. Sits between route selection (one-hot route_sel per input)
//  and the output link of a FlooNoC router; one instance per output port.
// PARAMETERS
//  NumInputs  4      number of requesting input ports (>=1)
//  flit_t     logic  flit struct; must contain hdr.last
//  IdxWidth   $clog2(NumInputs) (min 1)  width of grant index / rr pointer
// PORTS
//  clk_i        in   1                    clock, all state on rising edge
//  rst_i        in   1                    asynchronous reset, active-high
//  valid_i      in   NumInputs            per-input request (already qualified by route_sel)
//  ready_o      out  NumInputs            per-input accept
//  data_i       in   NumInputs x flit_t   per-input flit
//  valid_o      out  1                    output flit valid
//  ready_i      in   1                    downstream accept
//  data_o       out  flit_t               output flit (muxed from granted input)
//  locked_o     out  1                    1 while a multi-flit packet owns the output
//  grant_idx_o  out  IdxWidth             index of currently granted input (valid when valid_o)
// BEHAVIOUR
//  - Fully combinational data path, zero latency: data_o = data_i[grant], valid_o = valid_i[grant]
//    (IDLE: valid_o = |valid_i). ready_o[i] = ready_i & (i == grant) & valid_o; all others 0.
//  - Handshake = valid_o & ready_i. Inputs must hold valid/data stable until accepted.
//  - State: arb_state_e {ArbIdle, ArbLocked}; regs: state_q, rr_ptr_q, lock_idx_q.
//  - Reset (async, rst_i=1): state_q=ArbIdle, rr_ptr_q=0, lock_idx_q=0. Outputs then:
//    valid_o=|valid_i (combinational), locked_o=0, grant_idx_o = rr pick, ready_o per rule above.
//  - ArbIdle: grant = first i with valid_i[i], scanning cyclically from rr_ptr_q upward
//    (rr_ptr_q, +1, ..., N-1, 0, ...). No valid -> grant=rr_ptr_q, valid_o=0, ready_o=0.
//    On handshake: last=1 -> stay ArbIdle, rr_ptr_q <= grant+1 (wrap N-1 -> 0);
//    last=0 -> ArbLocked, lock_idx_q <= grant, rr_ptr_q unchanged.
//  - ArbLocked: grant = lock_idx_q regardless of other valids; valid_o = valid_i[lock_idx_q];
//    locked_o=1. Bubbles (owner valid low) keep the lock; others stay stalled.
//    On handshake with last=1 -> ArbIdle, rr_ptr_q <= lock_idx_q+1 (wrap).
//  - Single-flit packet (last=1 on first flit) never enters ArbLocked; pointer advances.
//  - ready_i low: no state change; grant and data_o held stable (IDLE grant changes only if
//    a higher-priority valid appears, which is legal because no handshake occurred).
//  - NumInputs=1: pointer/idx stay 0; arbiter degenerates to pass-through with lock tracking.
//  - Reset mid-packet: lock dropped, pointer to 0; recovery of partial packets is system-level.
//  - Sim-only assertions: owner drops valid_i without handshake while locked -> $error;
//    lock_idx_q < NumInputs; at most one ready_o bit set.
// STRUCTURE
//  - arb_state_e {ArbIdle, ArbLocked} added to floo_pkg; IdxWidth derived locally.
//  - Sub-module floo_rr_pick (combinational): inputs req[NumInputs], ptr[IdxWidth];
//    outputs idx, any; implemented as double-width priority scan (req masked >= ptr, else req).
//  - Top: state/pointer FFs, grant mux, ready demux, assertions.
// TESTING (NumInputs=4, ready_i=1 unless noted)
//  1 Reset: rst_i=1 with valid_i=4'b0000 -> valid_o=0, ready_o=0, locked_o=0, grant_idx_o=0.
//  2 RR single flits: valid_i=4'b1111, all last=1, 4 cycles -> grants 0,1,2,3, then 0 again.
//  3 Wormhole: in1 sends 3-flit packet (last on 3rd), in2 valid throughout -> outputs
//    in1,in1,in1 then in2; locked_o=1,1,0; ready_o[2]=0 during the 3 in1 cycles.
//  4 Bubble in lock: in0 2-flit packet, valid_i[0] low 2 cycles between flits, in3 valid ->
//    valid_o=0 for 2 cycles, in3 not granted until in0 last accepted.
//  5 Backpressure: ready_i=0 for 5 cycles mid-packet -> data_o stable, state/pointer unchanged.
//  6 Wrap + reset: ptr=3, only in0 valid -> grant 0, ptr->1; assert rst_i while locked ->
//    locked_o=0 same cycle (async), ptr=0 after release.

Source files
------------

// File: rtl/floo_pkg.sv
// floo_pkg: shared types for the FlooNoC router output arbiter.
//   arb_state_e  - wormhole arbiter state (idle / packet owns output)
//   hdr_t        - minimal flit header, carries the packet tail marker
//   floo_flit_t  - default flit used when no custom flit type is supplied
package floo_pkg;

  typedef enum logic [0:0] {
    ArbIdle   = 1'b0,
    ArbLocked = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic       last;
    logic [3:0] src_id;
  } hdr_t;

  typedef struct packed {
    hdr_t        hdr;
    logic [15:0] payload;
  } floo_flit_t;

endpackage

// File: rtl/floo_rr_pick.sv
// floo_rr_pick: combinational round-robin pick.
//   req_i  in  NumInputs  request vector
//   ptr_i  in  IdxWidth   highest-priority index this round
//   idx_o  out IdxWidth   first requester at or after ptr_i (cyclic); ptr_i if none
//   any_o  out 1          at least one request present
module floo_rr_pick
  import floo_pkg::*;
#(
  parameter int unsigned NumInputs = 4,
  parameter int unsigned IdxWidth  = (NumInputs > 1) ? $clog2(NumInputs) : 1
) (
  input  logic [NumInputs-1:0] req_i,
  input  logic [IdxWidth-1:0]  ptr_i,
  output logic [IdxWidth-1:0]  idx_o,
  output logic                 any_o
);

  logic [NumInputs-1:0] masked;
  logic [NumInputs-1:0] sel;

  // Equivalent of a double-width priority scan: requests at or above the
  // pointer win first; only if none exist do we wrap to the unmasked vector.
  always_comb begin
    masked = '0;
    for (int unsigned i = 0; i < NumInputs; i++) begin
      masked[i] = req_i[i] & (i >= 32'(ptr_i));
    end
    sel   = (|masked) ? masked : req_i;
    idx_o = ptr_i;
    for (int i = NumInputs - 1; i >= 0; i--) begin
      if (sel[i]) idx_o = IdxWidth'(i);
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/floo_wormhole_arbiter.sv
// floo_wormhole_arbiter: shares one router output among NumInputs inputs.
// A round-robin pick chooses a packet head; the winner then owns the output
// until its flit with hdr.last is transferred. Zero-latency data path.
//   clk_i        in   clock
//   rst_i        in   asynchronous reset, active-high
//   valid_i      in   per-input request
//   ready_o      out  per-input accept (only the granted input)
//   data_i       in   per-input flit
//   valid_o      out  output flit valid
//   ready_i      in   downstream accept
//   data_o       out  flit of the granted input
//   locked_o     out  a multi-flit packet currently owns the output
//   grant_idx_o  out  index of the granted input
module floo_wormhole_arbiter
  import floo_pkg::*;
#(
  parameter int unsigned NumInputs = 4,
  parameter type         flit_t    = floo_pkg::floo_flit_t,
  parameter int unsigned IdxWidth  = (NumInputs > 1) ? $clog2(NumInputs) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NumInputs-1:0] valid_i,
  output logic [NumInputs-1:0] ready_o,
  input  flit_t                data_i [NumInputs],
  output logic                 valid_o,
  input  logic                 ready_i,
  output flit_t                data_o,
  output logic                 locked_o,
  output logic [IdxWidth-1:0]  grant_idx_o
);

  arb_state_e          state_q, state_d;
  logic [IdxWidth-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxWidth-1:0] lock_idx_q, lock_idx_d;
  logic [IdxWidth-1:0] pick_idx;
  logic                pick_any;
  logic [IdxWidth-1:0] grant_idx;
  logic                handshake;

  function automatic logic [IdxWidth-1:0] next_idx(input logic [IdxWidth-1:0] idx);
    if (32'(idx) >= NumInputs - 1) return '0;
    return idx + IdxWidth'(1);
  endfunction

  floo_rr_pick #(
    .NumInputs (NumInputs),
    .IdxWidth  (IdxWidth)
  ) u_rr_pick (
    .req_i (valid_i),
    .ptr_i (rr_ptr_q),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // While locked, the owner keeps the grant even through bubbles.
  assign grant_idx   = (state_q == ArbLocked) ? lock_idx_q : pick_idx;
  assign grant_idx_o = grant_idx;
  assign locked_o    = (state_q == ArbLocked);
  assign handshake   = valid_o & ready_i;

  // Grant mux and ready demux
  always_comb begin
    data_o  = '0;
    valid_o = 1'b0;
    ready_o = '0;
    for (int unsigned i = 0; i < NumInputs; i++) begin
      if (32'(grant_idx) == i) begin
        data_o  = data_i[i];
        valid_o = valid_i[i];
      end
    end
    if (state_q == ArbIdle) valid_o = pick_any;
    for (int unsigned i = 0; i < NumInputs; i++) begin
      ready_o[i] = ready_i & valid_o & (32'(grant_idx) == i);
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_idx_d = lock_idx_q;
    unique case (state_q)
      ArbIdle: begin
        if (handshake) begin
          if (data_o.hdr.last) begin
            rr_ptr_d = next_idx(grant_idx);
          end else begin
            state_d    = ArbLocked;
            lock_idx_d = grant_idx;
          end
        end
      end
      ArbLocked: begin
        if (handshake && data_o.hdr.last) begin
          state_d  = ArbIdle;
          rr_ptr_d = next_idx(lock_idx_q);
        end
      end
      default: state_d = ArbIdle;
    endcase
  end

  // State registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ArbIdle;
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_idx_q <= lock_idx_d;
    end
  end

`ifndef SYNTHESIS
  owner_hold_a: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == ArbLocked && valid_o && !ready_i) |=> valid_o)
    else $error("locked owner dropped valid without handshake");

  lock_idx_range_a: assert property (@(posedge clk_i) disable iff (rst_i)
    32'(lock_idx_q) < NumInputs)
    else $error("lock_idx_q out of range");

  ready_onehot_a: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(ready_o))
    else $error("more than one ready_o bit set");
`endif

endmodule

// File: tb/tb_floo_wormhole_arbiter.sv
module tb_floo_wormhole_arbiter;
  import floo_pkg::*;

  localparam int N = 4;

  typedef struct packed {
    logic [1:0] idx;
    floo_flit_t flit;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [N-1:0]     valid_i;
  logic [N-1:0]     ready_o;
  floo_flit_t       data_i [N];
  logic             valid_o;
  logic             ready_i;
  floo_flit_t       data_o;
  logic             locked_o;
  logic [1:0]       grant_idx_o;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  floo_wormhole_arbiter #(
    .NumInputs (N),
    .flit_t    (floo_flit_t)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .data_i      (data_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .data_o      (data_o),
    .locked_o    (locked_o),
    .grant_idx_o (grant_idx_o)
  );

  function automatic floo_flit_t mk(input int src, input int seq, input logic last);
    floo_flit_t f;
    f.hdr.last   = last;
    f.hdr.src_id = 4'(src);
    f.payload    = 16'(src * 256 + seq);
    return f;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int idx, input floo_flit_t f);
    exp_t e;
    e.idx  = 2'(idx);
    e.flit = f;
    sb.push_back(e);
  endtask

  // One clock: at the falling edge any transfer is scored against the queue,
  // then return just after the next rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (valid_o === 1'b1 && ready_i === 1'b1) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_underflow observed=transfer expected=none");
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_grant", 32'(grant_idx_o), 32'(e.idx));
        chk("sb_data", 32'(data_o), 32'(e.flit));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    valid_i = '0;
    ready_i = 1'b1;
    for (int i = 0; i < N; i++) data_i[i] = mk(i, 0, 1'b1);

    // Reset with no requests
    #1 rst = 1'b1;
    #2;
    chk("rst_valid_o", 32'(valid_o), 32'd0);
    chk("rst_ready_o", 32'(ready_o), 32'd0);
    chk("rst_locked_o", 32'(locked_o), 32'd0);
    chk("rst_grant", 32'(grant_idx_o), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Round robin over single-flit packets: 0,1,2,3,0
    valid_i = 4'b1111;
    for (int k = 0; k < 5; k++) push(k % 4, mk(k % 4, 0, 1'b1));
    repeat (5) cycle();
    valid_i = '0;

    // Wormhole: in1 3-flit packet, in2 waiting (pointer now 1)
    valid_i = 4'b0110;
    data_i[2] = mk(2, 0, 1'b1);
    push(1, mk(1, 1, 1'b0));
    push(1, mk(1, 2, 1'b0));
    push(1, mk(1, 3, 1'b1));
    push(2, mk(2, 0, 1'b1));
    for (int k = 1; k <= 3; k++) begin
      data_i[1] = mk(1, k, (k == 3));
      #1;
      chk("wh_ready2", 32'(ready_o[2]), 32'd0);
      chk("wh_ready1", 32'(ready_o[1]), 32'd1);
      cycle();
      chk("wh_locked", 32'(locked_o), (k < 3) ? 32'd1 : 32'd0);
    end
    cycle();
    valid_i = '0;

    // Bubble inside a lock: in0 2-flit packet, in3 waiting (pointer now 3)
    valid_i = 4'b0001;
    data_i[0] = mk(0, 1, 1'b0);
    data_i[3] = mk(3, 0, 1'b1);
    push(0, mk(0, 1, 1'b0));
    cycle();
    chk("bub_locked", 32'(locked_o), 32'd1);
    valid_i = 4'b1000;
    repeat (2) begin
      #1;
      chk("bub_valid_o", 32'(valid_o), 32'd0);
      chk("bub_ready_o", 32'(ready_o), 32'd0);
      chk("bub_grant", 32'(grant_idx_o), 32'd0);
      cycle();
    end
    valid_i = 4'b1001;
    data_i[0] = mk(0, 2, 1'b1);
    push(0, mk(0, 2, 1'b1));
    push(3, mk(3, 0, 1'b1));
    #1;
    chk("bub_tail_grant", 32'(grant_idx_o), 32'd0);
    cycle();
    chk("bub_unlocked", 32'(locked_o), 32'd0);
    cycle();
    valid_i = '0;

    // Backpressure mid-packet (pointer now 0)
    valid_i = 4'b1100;
    data_i[2] = mk(2, 1, 1'b0);
    data_i[3] = mk(3, 1, 1'b1);
    push(2, mk(2, 1, 1'b0));
    cycle();
    data_i[2] = mk(2, 2, 1'b0);
    ready_i = 1'b0;
    repeat (5) begin
      #1;
      chk("bp_data", 32'(data_o), 32'(mk(2, 2, 1'b0)));
      chk("bp_grant", 32'(grant_idx_o), 32'd2);
      chk("bp_locked", 32'(locked_o), 32'd1);
      chk("bp_ready_o", 32'(ready_o), 32'd0);
      cycle();
    end
    ready_i = 1'b1;
    push(2, mk(2, 2, 1'b0));
    cycle();
    data_i[2] = mk(2, 3, 1'b1);
    push(2, mk(2, 3, 1'b1));
    push(3, mk(3, 1, 1'b1));
    cycle();
    chk("bp_unlocked", 32'(locked_o), 32'd0);
    cycle();
    valid_i = '0;

    // Pointer wrap, then reset while locked (pointer now 0)
    valid_i = 4'b0100;
    data_i[2] = mk(2, 4, 1'b1);
    push(2, mk(2, 4, 1'b1));
    cycle();
    valid_i = 4'b0001;
    data_i[0] = mk(0, 3, 1'b1);
    push(0, mk(0, 3, 1'b1));
    #1;
    chk("wrap_grant", 32'(grant_idx_o), 32'd0);
    cycle();
    valid_i = 4'b0011;
    data_i[1] = mk(1, 4, 1'b0);
    push(1, mk(1, 4, 1'b0));
    #1;
    chk("ptr1_grant", 32'(grant_idx_o), 32'd1);
    cycle();
    chk("pre_rst_locked", 32'(locked_o), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_locked", 32'(locked_o), 32'd0);
    chk("async_rst_grant", 32'(grant_idx_o), 32'd0);
    #1 rst = 1'b0;
    push(0, mk(0, 3, 1'b1));
    cycle();
    valid_i = '0;
    repeat (2) cycle();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
